// File: rtl/button_debouncer_if.sv
// Button conditioning bus: raw pins and sticky-clear in, clean levels,
// edge pulses and sticky press flags out.
interface button_debouncer_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] clr_sticky;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic [N_BTN-1:0] btn_sticky;

  // Board pins / CPU decode side: drives raw levels and clears, reads results.
  modport master (
    output btn_raw,
    output clr_sticky,
    input  btn_stable,
    input  btn_rise,
    input  btn_fall,
    input  btn_sticky
  );

  // Debouncer side.
  modport slave (
    input  btn_raw,
    input  clr_sticky,
    output btn_stable,
    output btn_rise,
    output btn_fall,
    output btn_sticky
  );
endinterface

// File: rtl/button_debouncer.sv
// Per-bit push-button debouncer: two-flop synchronizer, hold-time filter,
// registered rise/fall pulses and software-clearable sticky press flags.
module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  button_debouncer_if.slave bus
);

  // Last count value before a new level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] rise_q, rise_d;
  logic [N_BTN-1:0] fall_q, fall_d;
  logic [N_BTN-1:0] sticky_q, sticky_d;

  // Two-stage synchronizer for the asynchronous pins; only sync2_q is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // One independent hold-time filter per button.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_bit_d;

    // Count consecutive mismatching cycles; any agreement restarts from zero,
    // and reaching the limit accepts the new level and clears the count.
    always_comb begin
      cnt_d        = '0;
      stable_bit_d = stable_q[gi];
      if (sync2_q[gi] != stable_q[gi]) begin
        if (cnt_q == CNT_MAX) begin
          stable_bit_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Counter register; reset discards any partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[gi] = stable_bit_d;
  end

  // Edge pulses line up with the cycle in which the new level first appears;
  // a coincident press beats a clear so no press is lost.
  always_comb begin
    rise_d   = stable_d & ~stable_q;
    fall_d   = ~stable_d & stable_q;
    sticky_d = rise_d | (sticky_q & ~bus.clr_sticky);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      sticky_q <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.btn_stable = stable_q;
  assign bus.btn_rise   = rise_q;
  assign bus.btn_fall   = fall_q;
  assign bus.btn_sticky = sticky_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with a short debounce window. The reference
// model keeps the full history of driven inputs and decides each cycle's
// outputs from a sliding-window rule over that history.
module tb_button_debouncer;

  localparam int NB = 5;
  localparam int DC = 4;

  logic clk;
  logic rst;

  button_debouncer_if #(.N_BTN(NB)) bus ();

  button_debouncer #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Input history, one entry per clock edge.
  logic [NB-1:0] raw_h[$];
  bit            rst_h[$];

  // Model state after the most recent edge.
  logic [NB-1:0] m_stable;
  logic [NB-1:0] m_sticky;
  int            t_now;

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", tag, t_now, got, exp);
    end
  endtask

  // Level the filter sees at edge t: the pin value sampled two edges
  // earlier, or 0 if a reset in between flushed the synchronizer.
  function automatic logic [NB-1:0] seen_at(input int t);
    if (t < 2) return '0;
    if (rst_h[t-1] || rst_h[t-2]) return '0;
    return raw_h[t-2];
  endfunction

  // Drive one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input logic [NB-1:0] raw, input logic [NB-1:0] clr, input bit r);
    logic [NB-1:0] st_new, rise_e, fall_e, stk_new, s;
    int t;
    bit ok;
    bus.btn_raw    = raw;
    bus.clr_sticky = clr;
    rst            = r;
    raw_h.push_back(raw);
    rst_h.push_back(r);
    @(posedge clk);
    t = raw_h.size() - 1;
    t_now = t;
    st_new = m_stable;
    if (r) begin
      st_new = '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        // A new level is accepted once the filter has seen it on DC
        // consecutive edges with no reset among them.
        ok = (t >= DC - 1);
        for (int k = t - (DC - 1); ok && k <= t; k++) begin
          s = seen_at(k);
          if (k < t && rst_h[k]) ok = 1'b0;
          if (s[i] == m_stable[i]) ok = 1'b0;
        end
        if (ok) st_new[i] = ~m_stable[i];
      end
    end
    rise_e  = r ? '0 : (st_new & ~m_stable);
    fall_e  = r ? '0 : (~st_new & m_stable);
    stk_new = r ? '0 : (rise_e | (m_sticky & ~clr));
    m_stable = st_new;
    m_sticky = stk_new;
    #1;
    chk("stable", bus.btn_stable, m_stable);
    chk("rise",   bus.btn_rise,   rise_e);
    chk("fall",   bus.btn_fall,   fall_e);
    chk("sticky", bus.btn_sticky, m_sticky);
    if ((bus.btn_rise & bus.btn_fall) != '0) begin
      chk("rise_fall_excl", bus.btn_rise & bus.btn_fall, '0);
    end
  endtask

  task automatic hold(input logic [NB-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, '0, 1'b0);
  endtask

  int            hold_left[NB];
  logic [NB-1:0] rnd_raw;
  logic [NB-1:0] rnd_clr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_stable = '0;
    m_sticky = '0;
    t_now    = 0;
    rst      = 1'b1;
    bus.btn_raw    = '0;
    bus.clr_sticky = '0;

    // Reset held with all buttons pressed, then release reset.
    for (int i = 0; i < 3; i++) step(5'b11111, '0, 1'b1);
    hold(5'b11111, 8);
    $display("phase reset: done at edge %0d", t_now);

    // Release everything and clear all sticky flags.
    hold(5'b00000, 8);
    step(5'b00000, 5'b11111, 1'b0);
    hold(5'b00000, 2);
    $display("phase release_clear: done at edge %0d", t_now);

    // Clean press and release on bit 0.
    hold(5'b00001, 8);
    hold(5'b00000, 8);
    $display("phase clean_press: done at edge %0d", t_now);

    // Bouncing bit 2 before a solid hold.
    for (int b = 0; b < 4; b++) hold((b % 2 == 0) ? 5'b00100 : 5'b00000, 2);
    hold(5'b00100, 8);
    hold(5'b00000, 8);
    $display("phase bounce: done at edge %0d", t_now);

    // Short glitch on bit 1 must be rejected.
    hold(5'b00010, 3);
    hold(5'b00000, 8);
    $display("phase glitch: done at edge %0d", t_now);

    // Sticky clear, then clear coinciding with a new rise on bit 3.
    hold(5'b01000, 8);
    step(5'b01000, 5'b01000, 1'b0);
    hold(5'b01000, 1);
    hold(5'b00000, 8);
    hold(5'b01000, 5);
    step(5'b01000, 5'b01000, 1'b0);
    hold(5'b01000, 3);
    hold(5'b00000, 8);
    $display("phase sticky_race: done at edge %0d", t_now);

    // Reset partway through a count on bit 4 with the button held.
    hold(5'b10000, 5);
    step(5'b10000, '0, 1'b1);
    hold(5'b10000, 8);
    hold(5'b00000, 8);
    $display("phase midcount_reset: done at edge %0d", t_now);

    // Randomized per-bit levels with hold times both shorter and longer
    // than the window, random clears and occasional resets.
    rnd_raw = '0;
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          rnd_raw[i]   = $urandom_range(0, 1);
          hold_left[i] = $urandom_range(1, 8);
        end
        hold_left[i]--;
        rnd_clr[i] = ($urandom_range(0, 3) == 0);
      end
      step(rnd_raw, rnd_clr, $urandom_range(0, 99) == 0);
    end
    $display("phase random: done at edge %0d", t_now);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
